mini_soc_ahb_sram: RTL and testbench
====================================

# mini_soc_ahb_sram

AHB-Lite slave SRAM sitting directly downstream of the mini SoC's AHB master port. It accepts the SoC's address/control, write data and transfer qualifiers, and returns `hrdata`, `hready` and `hresp`. It provides word-addressed on-chip storage with byte/halfword/word lanes and a programmable number of wait states. It is the single slave on the bus, so its `hready` is the bus-wide ready.

## Interface
- `DEPTH`, default 256: storage size in 32-bit words; power of two, 16..4096.
- `WAIT_STATES`, default 1: `hready`-low cycles inserted in every NONSEQ/SEQ data phase; 0..7.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hsel` in 1: slave select.
- `htrans` in 2: transfer type. 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `haddr` in 32: byte address.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: 000 byte, 001 halfword, 010 word.
- `hburst` in 3: accepted and ignored; every beat is addressed individually.
- `hwdata` in 32: write data, valid in the data phase.
- `hrdata` out 32: read data.
- `hready` out 1: transfer done / bus ready.
- `hresp` out 1: 0 OKAY, 1 ERROR.

## Operation
- **Address phase accept:** a transfer is accepted on a rising edge where `hready`=1, `hsel`=1 and `htrans[1]`=1. On acceptance the block registers `haddr`, `hwrite` and `hsize`.
- **Non-accepted phases:** if `hsel`=0, or `htrans` is IDLE or BUSY, nothing is accepted. The next cycle is an OKAY cycle with zero wait and `hready`=1.
- **State machine:** IDLE, WAIT, ERR1, ERR2.
  - IDLE → WAIT when a transfer is accepted and `WAIT_STATES`>0.
  - IDLE stays in IDLE and completes the accepted transfer in the next cycle when `WAIT_STATES`=0.
  - WAIT counts `WAIT_STATES` cycles with `hready`=0, then completes with `hready`=1 and returns to IDLE. It may accept a new transfer on that same edge (back-to-back).
  - An erroneous accepted transfer goes to ERR1 (`hready`=0, `hresp`=1), then ERR2 (`hready`=1, `hresp`=1), then IDLE. Erroneous transfers insert no wait states.
- **Word index:** `haddr[log2(DEPTH)+1:2]`.
- **Byte lanes (little-endian):**
  - byte: lane `haddr[1:0]`.
  - halfword: lanes {1,0} if `haddr[1]`=0, else {3,2}.
  - word: all lanes.
- **Writes:** only the enabled lanes of `hwdata` are written. `hwdata` is sampled on the completing edge of the data phase (`hready`=1).
- **Reads:** `hrdata` returns the full 32-bit word regardless of `hsize`. It is valid only in the completing cycle and holds its last value otherwise.
- **Read-after-write:** a read whose address phase overlaps the data phase of a preceding write (`WAIT_STATES`=0) returns the newly written data, via a forward/bypass path.
- **Memory contents:** not reset; undefined until written.

## Timing
- **Reset values:** `hready`=1, `hresp`=0, `hrdata`=0, state IDLE, wait counter 0.
- **Latency:** address phase accepted at edge N; data phase completes at edge N+1+`WAIT_STATES`.
- **Error response:** always exactly two cycles. ERR1 at N+1, ERR2 at N+2; the next accept is possible at edge N+2.
- **Pipelining:** a back-to-back NONSEQ/SEQ stream completes one beat per `WAIT_STATES`+1 cycles.
- **`hresp`** is 0 in every cycle except ERR1 and ERR2.
- **Reset mid-transfer:** asynchronously returns outputs to their reset values immediately. A pending write is dropped and the memory is unchanged.
- **Boundary:** the last word (`DEPTH`-1) is legal. `haddr` = `DEPTH`*4 is out of range (see Configuration).

## Configuration
- **`MINI_SOC_AHB_SRAM_ERR_EN` defined:**
  - ERROR response for: `haddr` ≥ `DEPTH`*4; `hsize` > 010; misalignment (halfword with `haddr[0]`=1, or word with `haddr[1:0]`≠0).
  - An erroneous write leaves the memory unchanged.
- **Not defined:**
  - `hresp` is tied to 0.
  - Out-of-range addresses wrap modulo `DEPTH` words.
  - `hsize` > 010 is treated as a word access.
  - Misaligned accesses use the aligned lane group (`haddr[0]` ignored for halfword, `haddr[1:0]` ignored for word).
  - ERR1 and ERR2 are not built.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT → `hready`=1, `hresp`=0, `hrdata`=0 immediately; the pending write to 0x10 is not visible on a later read.
- **Word write/read:** `WAIT_STATES`=2. Write 0xDEADBEEF to 0x40, then read 0x40 → `hready` low for exactly 2 cycles in each data phase; read returns 0xDEADBEEF with `hresp`=0.
- **Byte lanes:** write word 0x11223344 to 0x80; write byte 0xAA to 0x81; write halfword 0xBBCC to 0x82; read 0x80 → 0xBBCCAA44.
- **Back-to-back forwarding:** `WAIT_STATES`=0. Write 0x12345678 to 0x08 immediately followed by a read of 0x08 → read returns 0x12345678 one cycle later; no `hready` low.
- **Errors with `MINI_SOC_AHB_SRAM_ERR_EN`:** read 0x400 (`DEPTH`=256) → ERR1 (`hready`=0, `hresp`=1), then ERR2 (`hready`=1, `hresp`=1). A word write to 0x02 gives the same two-cycle ERROR and memory is unchanged.
- **Wrap without the macro:** write 0xCAFEF00D to 0x404, read 0x004 → 0xCAFEF00D, `hresp`=0.

Source files
------------

// File: rtl/mini_soc_ahb_sram.sv
// mini_soc_ahb_sram: AHB-Lite single-slave SRAM, byte lanes, programmable wait states.
// Define MINI_SOC_AHB_SRAM_ERR_EN for ERROR responses on out-of-range/bad transfers.
module mini_soc_ahb_sram #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic pend_q;
  logic wr_q;
  logic [3:0] be_q;
  logic [AW-1:0] idx_q;

  logic [31:0] mem [DEPTH];

  logic accept;
  logic bad;
  logic done;
  logic rd_load;
  logic [AW-1:0] idx;
  logic [AW-1:0] rd_idx;
  logic [3:0] be;
  logic [31:0] rd_word;
  logic unused_ok;

  assign unused_ok = ^{hburst, haddr[31:AW+2]};
  assign idx = haddr[AW+1:2];

  always_comb begin
    be = 4'b1111;
    unique case (1'b1)
      hsize == 3'd0: be = 4'b0001 << haddr[1:0];
      hsize == 3'd1: be = haddr[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
  end

`ifdef MINI_SOC_AHB_SRAM_ERR_EN
  always_comb begin
    bad = 1'b0;
    if (haddr[31:AW+2] != '0) bad = 1'b1;
    if (hsize > 3'd2) bad = 1'b1;
    if (hsize == 3'd1 && haddr[0]) bad = 1'b1;
    if (hsize == 3'd2 && haddr[1:0] != 2'd0) bad = 1'b1;
  end
  assign hresp = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
  assign bad   = 1'b0;
  assign hresp = 1'b0;
`endif

  always_comb begin
    hready = 1'b1;
    unique case (state_q)
      S_WAIT:  hready = (cnt_q == 3'd0);
      S_ERR1:  hready = 1'b0;
      default: hready = 1'b1;
    endcase
  end

  assign accept = hready && hsel && htrans[1];
  assign done   = pend_q && hready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_WAIT:  if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      S_ERR1:  state_d = S_ERR2;
      default: ;
    endcase
    // every ready cycle is a potential address phase
    if (hready) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      if (accept) begin
        if (bad) begin
          state_d = S_ERR1;
        end else if (WS != 3'd0) begin
          state_d = S_WAIT;
          cnt_d   = WS;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hready) begin
        pend_q <= accept && !bad;
        if (accept) begin
          wr_q  <= hwrite;
          be_q  <= be;
          idx_q <= idx;
        end
      end
    end
  end

  // zero-wait reads sample in the address phase, so merge a completing write
  assign rd_idx  = (WAIT_STATES == 0) ? idx : idx_q;
  assign rd_load = (WAIT_STATES == 0) ? (accept && !bad && !hwrite)
                 : (state_q == S_WAIT && cnt_q == 3'd1 && !wr_q);

  always_comb begin
    rd_word = mem[rd_idx];
    if (done && wr_q && idx_q == rd_idx) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hrdata <= 32'd0;
    end else if (rd_load) begin
      hrdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_mini_soc_ahb_sram.sv
// tb_mini_soc_ahb_sram: random AHB traffic on a zero-wait and a two-wait SRAM
// against a word-array reference model.
module tb_mini_soc_ahb_sram;
  localparam int DEPTH = 256;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    int          gap;
  } op_t;

  logic clk;
  logic rst_n;
  logic        hsel_v   [2];
  logic [1:0]  htrans_v [2];
  logic [31:0] haddr_v  [2];
  logic        hwrite_v [2];
  logic [2:0]  hsize_v  [2];
  logic [2:0]  hburst_v [2];
  logic [31:0] hwdata_v [2];
  logic [31:0] hrdata_v [2];
  logic        hready_v [2];
  logic        hresp_v  [2];

  logic [31:0] ref_mem [2][DEPTH];
  op_t ops[$];
  logic [31:0] last_rd;
  int n_chk;
  int n_fail;

  mini_soc_ahb_sram #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .hsel(hsel_v[0]), .htrans(htrans_v[0]), .haddr(haddr_v[0]),
    .hwrite(hwrite_v[0]), .hsize(hsize_v[0]), .hburst(hburst_v[0]),
    .hwdata(hwdata_v[0]), .hrdata(hrdata_v[0]),
    .hready(hready_v[0]), .hresp(hresp_v[0])
  );

  mini_soc_ahb_sram #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .hsel(hsel_v[1]), .htrans(htrans_v[1]), .haddr(haddr_v[1]),
    .hwrite(hwrite_v[1]), .hsize(hsize_v[1]), .hburst(hburst_v[1]),
    .hwdata(hwdata_v[1]), .hrdata(hrdata_v[1]),
    .hready(hready_v[1]), .hresp(hresp_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", tag, got, want);
    end
  endtask

  function automatic int ws_of(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  function automatic logic [3:0] lanes(input logic [31:0] a,
                                       input logic [2:0] s);
    if (s == 3'd0) return 4'b0001 << a[1:0];
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit is_bad(input op_t o);
    bit b;
    b = 1'b0;
`ifdef MINI_SOC_AHB_SRAM_ERR_EN
    b = (o.addr >= 32'(DEPTH * 4)) || (o.size > 3'd2) ||
        (o.size == 3'd1 && o.addr[0]) ||
        (o.size == 3'd2 && o.addr[1:0] != 2'd0);
`endif
    return b;
  endfunction

  task automatic set_off(input int u);
    hsel_v[u]   = 1'b0;
    htrans_v[u] = 2'b00;
    haddr_v[u]  = 32'd0;
    hwrite_v[u] = 1'b0;
    hsize_v[u]  = 3'd0;
    hburst_v[u] = 3'd0;
    hwdata_v[u] = 32'd0;
  endtask

  task automatic drive_idle(input int u);
    case ($urandom_range(0, 2))
      0: begin hsel_v[u] = 1'b0; htrans_v[u] = 2'b10; end
      1: begin hsel_v[u] = 1'b1; htrans_v[u] = 2'b00; end
      default: begin hsel_v[u] = 1'b1; htrans_v[u] = 2'b01; end
    endcase
    haddr_v[u]  = $urandom;
    hwrite_v[u] = 1'($urandom_range(0, 1));
    hsize_v[u]  = 3'($urandom_range(0, 2));
  endtask

  task automatic add(input bit wr, input logic [31:0] addr,
                     input logic [2:0] size, input logic [31:0] data,
                     input int gap);
    op_t o;
    o.wr = wr; o.addr = addr; o.size = size; o.data = data; o.gap = gap;
    ops.push_back(o);
  endtask

  task automatic gen(input int n);
    for (int i = 0; i < n; i++) begin
      op_t o;
      int r;
      r = $urandom_range(0, 15);
      o.wr   = 1'($urandom_range(0, 1));
      o.size = 3'($urandom_range(0, 2));
      o.addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      if (r == 0) o.addr = o.addr + 32'(DEPTH * 4 * $urandom_range(1, 3));
      if (r == 1) o.size = 3'($urandom_range(3, 7));
      if (r > 1 && r < 12 && o.size < 3'd3)
        o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
      o.data = $urandom;
      o.gap  = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
      ops.push_back(o);
    end
  endtask

  task automatic complete(input int u, input op_t o, input bit bad,
                          input logic [31:0] rd);
    int idx;
    logic [3:0] ln;
    idx = int'(o.addr[31:2] % DEPTH);
    ln  = lanes(o.addr, o.size);
    if (!bad) begin
      if (o.wr) begin
        for (int b = 0; b < 4; b++)
          if (ln[b]) ref_mem[u][idx][8*b +: 8] = o.data[8*b +: 8];
      end else begin
        chk("rdata", rd, ref_mem[u][idx]);
        last_rd = rd;
      end
    end
  endtask

  // cycle-level master: one address phase and one data phase in flight
  task automatic run_ops(input int u);
    op_t ap, dp;
    bit ap_v, dp_v, dp_bad;
    int k, gap, guard;
    logic hr, hp;
    logic [31:0] rd;
    logic [1:0] want;
    ap_v = 0; dp_v = 0; dp_bad = 0; k = 0; gap = 0; guard = 0;
    while ((ops.size() > 0 || ap_v || dp_v) && guard < 6000) begin
      guard++;
      if (!ap_v && ops.size() > 0) begin
        ap = ops.pop_front();
        ap_v = 1;
        gap = ap.gap;
      end
      if (ap_v && gap == 0) begin
        hsel_v[u]   = 1'b1;
        htrans_v[u] = {1'b1, 1'($urandom_range(0, 1))};
        haddr_v[u]  = ap.addr;
        hwrite_v[u] = ap.wr;
        hsize_v[u]  = ap.size;
      end else begin
        drive_idle(u);
      end
      hburst_v[u] = 3'($urandom_range(0, 7));
      hwdata_v[u] = (dp_v && dp.wr) ? dp.data : $urandom;
      @(negedge clk);
      hr = hready_v[u];
      hp = hresp_v[u];
      rd = hrdata_v[u];
      if (dp_v) begin
        if (dp_bad) want = (k == 0) ? 2'b01 : 2'b11;
        else want = (k < ws_of(u)) ? 2'b00 : 2'b10;
        chk("hs", {30'd0, hr, hp}, {30'd0, want});
        k++;
        if (hr) begin
          complete(u, dp, dp_bad, rd);
          dp_v = 0;
        end else if (k > 12) begin
          chk("dphase_len", 32'(k), 32'(ws_of(u) + 1));
          dp_v = 0;
        end
      end else begin
        chk("idle", {30'd0, hr, hp}, 32'b10);
      end
      @(posedge clk);
      #1;
      if (hr && ap_v && gap == 0) begin
        dp = ap; dp_v = 1; dp_bad = is_bad(ap); k = 0; ap_v = 0;
      end else if (gap > 0) begin
        gap--;
      end
    end
    if (guard >= 6000) chk("guard", 32'(guard), 32'd0);
    set_off(u);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    last_rd = 32'd0;
    rst_n = 1'b0;
    set_off(0);
    set_off(1);
    #3;
    for (int u = 0; u < 2; u++) begin
      chk("rst_hready", {31'd0, hready_v[u]}, 32'd1);
      chk("rst_hresp", {31'd0, hresp_v[u]}, 32'd0);
      chk("rst_hrdata", hrdata_v[u], 32'd0);
    end
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < DEPTH; w++) add(1, 32'(w * 4), 3'd2, $urandom, 0);
      run_ops(u);
    end

    add(1, 32'h08, 3'd2, 32'h12345678, 0);
    add(0, 32'h08, 3'd2, 32'd0, 0);
    run_ops(0);
    chk("fwd_word", last_rd, 32'h12345678);
    add(1, 32'h09, 3'd0, {4{8'h5A}}, 0);
    add(0, 32'h08, 3'd2, 32'd0, 0);
    run_ops(0);
    chk("fwd_byte", last_rd, 32'h12345A78);

    add(1, 32'h40, 3'd2, 32'hDEADBEEF, 0);
    add(0, 32'h40, 3'd2, 32'd0, 0);
    run_ops(1);
    chk("word_rd", last_rd, 32'hDEADBEEF);
    add(1, 32'h80, 3'd2, 32'h11223344, 0);
    add(1, 32'h81, 3'd0, {4{8'hAA}}, 1);
    add(1, 32'h82, 3'd1, {2{16'hBBCC}}, 0);
    add(0, 32'h80, 3'd2, 32'd0, 2);
    run_ops(1);
    chk("lanes", last_rd, 32'hBBCCAA44);

    for (int u = 0; u < 2; u++) begin
`ifdef MINI_SOC_AHB_SRAM_ERR_EN
      add(0, 32'h400, 3'd2, 32'd0, 0);
      add(1, 32'h02, 3'd2, 32'hFFFFFFFF, 0);
      add(0, 32'h00, 3'd2, 32'd0, 0);
      run_ops(u);
      chk("err_nowrite", last_rd, ref_mem[1][0] & {32{u == 1}} |
                                  ref_mem[0][0] & {32{u == 0}});
`else
      add(1, 32'h404, 3'd2, 32'hCAFEF00D, 0);
      add(0, 32'h004, 3'd2, 32'd0, 0);
      run_ops(u);
      chk("wrap", last_rd, 32'hCAFEF00D);
`endif
    end

    gen(300);
    run_ops(0);
    gen(300);
    run_ops(1);

    add(0, 32'h40, 3'd2, 32'd0, 0);
    run_ops(1);
    hsel_v[1]   = 1'b1;
    htrans_v[1] = 2'b10;
    haddr_v[1]  = 32'h10;
    hwrite_v[1] = 1'b1;
    hsize_v[1]  = 3'd2;
    @(posedge clk);
    #1;
    set_off(1);
    hwdata_v[1] = 32'h5555AAAA;
    @(negedge clk);
    chk("rst_wait", {31'd0, hready_v[1]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_hready", {31'd0, hready_v[1]}, 32'd1);
    chk("mid_hresp", {31'd0, hresp_v[1]}, 32'd0);
    chk("mid_hrdata", hrdata_v[1], 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    add(0, 32'h10, 3'd2, 32'd0, 0);
    run_ops(1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
